// File: rtl/boarding_tally.sv
// Passenger/crew boarding tally: two saturating counters sealed into an operand pair.
// Optional TALLY_STICKY_ERR_EN makes err_ovf/err_unf/err_drop sticky instead of pulsed.
module boarding_tally #(
  parameter int CNT_W    = 4,
  parameter int MAX_PASS = 15,
  parameter int MAX_CREW = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pass_inc,
  input  logic             pass_dec,
  input  logic             crew_inc,
  input  logic             crew_dec,
  input  logic             clear,
  input  logic             seal,
  input  logic             reopen,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] op_a,
  output logic [CNT_W-1:0] op_b,
  output logic             busy,
  output logic             err_ovf,
  output logic             err_unf,
  output logic             err_drop
);

  typedef enum logic [1:0] {
    S_OPEN,
    S_PRESENT,
    S_LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] P_MAX = CNT_W'(MAX_PASS);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_CREW);
  localparam logic [CNT_W-1:0] ZERO  = '0;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_crew;
  logic [CNT_W-1:0] w_pass_nxt;
  logic [CNT_W-1:0] w_crew_nxt;
  logic             w_open;
  logic             w_clr;
  logic             w_pass_ovf;
  logic             w_pass_unf;
  logic             w_crew_ovf;
  logic             w_crew_unf;
  logic             w_ovf_ev;
  logic             w_unf_ev;
  logic             w_drop_ev;
  logic             w_any_pulse;
  logic             r_err_ovf;
  logic             r_err_unf;
  logic             r_err_drop;

  assign w_open      = (r_state == S_OPEN);
  assign w_clr       = w_open & clear;
  assign w_any_pulse = pass_inc | pass_dec
                     | crew_inc | crew_dec;

  // clear beats inc/dec, and suppresses their error events
  always_comb begin
    w_pass_nxt = r_pass;
    w_pass_ovf = 1'b0;
    w_pass_unf = 1'b0;
    if (w_clr) begin
      w_pass_nxt = ZERO;
    end else if (w_open && (pass_inc ^ pass_dec)) begin
      if (pass_inc) begin
        if (r_pass == P_MAX) w_pass_ovf = 1'b1;
        else                 w_pass_nxt = r_pass + ONE;
      end else begin
        if (r_pass == ZERO)  w_pass_unf = 1'b1;
        else                 w_pass_nxt = r_pass - ONE;
      end
    end
  end

  always_comb begin
    w_crew_nxt = r_crew;
    w_crew_ovf = 1'b0;
    w_crew_unf = 1'b0;
    if (w_clr) begin
      w_crew_nxt = ZERO;
    end else if (w_open && (crew_inc ^ crew_dec)) begin
      if (crew_inc) begin
        if (r_crew == C_MAX) w_crew_ovf = 1'b1;
        else                 w_crew_nxt = r_crew + ONE;
      end else begin
        if (r_crew == ZERO)  w_crew_unf = 1'b1;
        else                 w_crew_nxt = r_crew - ONE;
      end
    end
  end

  assign w_ovf_ev  = w_pass_ovf | w_crew_ovf;
  assign w_unf_ev  = w_pass_unf | w_crew_unf;
  assign w_drop_ev = ~w_open & w_any_pulse;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_OPEN: begin
        if (seal) w_state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready) w_state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        if (reopen) w_state_nxt = S_OPEN;
      end
      default: w_state_nxt = S_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OPEN;
      r_pass  <= ZERO;
      r_crew  <= ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_pass  <= w_pass_nxt;
      r_crew  <= w_crew_nxt;
    end
  end

`ifdef TALLY_STICKY_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf  <= 1'b0;
      r_err_unf  <= 1'b0;
      r_err_drop <= 1'b0;
    end else if (w_clr) begin
      r_err_ovf  <= 1'b0;
      r_err_unf  <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      r_err_ovf  <= r_err_ovf  | w_ovf_ev;
      r_err_unf  <= r_err_unf  | w_unf_ev;
      r_err_drop <= r_err_drop | w_drop_ev;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf  <= 1'b0;
      r_err_unf  <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      r_err_ovf  <= w_ovf_ev;
      r_err_unf  <= w_unf_ev;
      r_err_drop <= w_drop_ev;
    end
  end
`endif

  assign out_valid = (r_state == S_PRESENT);
  assign busy      = ~w_open;
  assign op_a      = r_pass;
  assign op_b      = r_crew;
  assign err_ovf   = r_err_ovf;
  assign err_unf   = r_err_unf;
  assign err_drop  = r_err_drop;

endmodule

// File: tb/tb_boarding_tally.sv
// Directed bench for boarding_tally; operand pairs are scoreboarded at seal
// and checked when the handshake transfers them.
module tb_boarding_tally;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pass_inc = 1'b0;
  logic       pass_dec = 1'b0;
  logic       crew_inc = 1'b0;
  logic       crew_dec = 1'b0;
  logic       clear = 1'b0;
  logic       seal = 1'b0;
  logic       reopen = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       busy;
  logic       err_ovf;
  logic       err_unf;
  logic       err_drop;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_pair;
  logic [3:0] held_a;
  logic [3:0] held_b;

`ifdef TALLY_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  boarding_tally dut (
    .clk(clk), .rst_n(rst_n),
    .pass_inc(pass_inc), .pass_dec(pass_dec),
    .crew_inc(crew_inc), .crew_dec(crew_dec),
    .clear(clear), .seal(seal), .reopen(reopen),
    .out_ready(out_ready), .out_valid(out_valid),
    .op_a(op_a), .op_b(op_b), .busy(busy),
    .err_ovf(err_ovf), .err_unf(err_unf),
    .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        0: pass_inc = 1'b1;
        1: pass_dec = 1'b1;
        2: crew_inc = 1'b1;
        default: crew_dec = 1'b1;
      endcase
      tick();
      pass_inc = 1'b0; pass_dec = 1'b0;
      crew_inc = 1'b0; crew_dec = 1'b0;
    end
  endtask

  // compare the transferring pair against the scoreboard
  task automatic take(input string tag);
    out_ready = 1'b1;
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_pair = sb_q.pop_front();
      chk({tag, "_pair"}, {24'd0, op_a, op_b}, 32'(exp_pair));
    end
    tick();
    out_ready = 1'b0;
    chk({tag, "_locked_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_locked_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops", {24'd0, op_a, op_b}, 32'd0);
    chk("rst_errs", {29'd0, err_ovf, err_unf, err_drop}, 32'd0);
    rst_n = 1'b1;
    tick();

    // T2 count and seal
    pulse(0, 5);
    pulse(2, 3);
    pulse(3, 1);
    seal = 1'b1;
    sb_q.push_back({4'd5, 4'd2});
    tick();
    seal = 1'b0;
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_op_a", 32'(op_a), 32'd5);
    chk("t2_op_b", 32'(op_b), 32'd2);

    // T3 stall then transfer
    held_a = 4'd5;
    held_b = 4'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_stall_valid", 32'(out_valid), 32'd1);
      chk("t3_stall_ops", {24'd0, op_a, op_b}, {24'd0, held_a, held_b});
    end
    take("t3");

    // T6 pulses while locked
    crew_inc = 1'b1;
    tick();
    crew_inc = 1'b0;
    chk("t6_drop_op_b", 32'(op_b), 32'd2);
    chk("t6_err_drop", 32'(err_drop), 32'd1);
    seal = 1'b1;
    tick();
    seal = 1'b0;
    chk("t6_seal_ign_valid", 32'(out_valid), 32'd0);
    chk("t6_seal_ign_busy", 32'(busy), 32'd1);
    chk("t6_drop_hold", 32'(err_drop), 32'(STICKY));
    reopen = 1'b1;
    tick();
    reopen = 1'b0;
    chk("t6_reopen_busy", 32'(busy), 32'd0);
    chk("t6_retained", {24'd0, op_a, op_b}, {24'd0, 4'd5, 4'd2});

    // T4 saturation (5 + 17 incs hits the ceiling)
    pass_inc = 1'b1;
    repeat (17) tick();
    pass_inc = 1'b0;
    chk("t4_sat_op_a", 32'(op_a), 32'd15);
    chk("t4_err_ovf", 32'(err_ovf), 32'd1);
    tick();
    chk("t4_ovf_hold", 32'(err_ovf), 32'(STICKY));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_clear_ops", {24'd0, op_a, op_b}, 32'd0);
    chk("t4_clear_errs", {29'd0, err_ovf, err_unf, err_drop}, 32'd0);
    pulse(3, 1);
    chk("t4_unf_op_b", 32'(op_b), 32'd0);
    chk("t4_err_unf", 32'(err_unf), 32'd1);
    tick();
    chk("t4_unf_hold", 32'(err_unf), 32'(STICKY));

    // T5 simultaneous events
    pulse(0, 7);
    pass_inc = 1'b1;
    pass_dec = 1'b1;
    tick();
    pass_inc = 1'b0;
    pass_dec = 1'b0;
    chk("t5_incdec_hold", 32'(op_a), 32'd7);
    pulse(0, 2);
    chk("t5_pre_op_a", 32'(op_a), 32'd9);
    seal = 1'b1;
    clear = 1'b1;
    pass_inc = 1'b1;
    sb_q.push_back({4'd0, 4'd0});
    tick();
    seal = 1'b0;
    clear = 1'b0;
    pass_inc = 1'b0;
    chk("t5_sc_valid", 32'(out_valid), 32'd1);
    chk("t5_sc_op_a", 32'(op_a), 32'd0);
    take("t5");

    // T1 async reset mid-PRESENT drops the pending pair
    reopen = 1'b1;
    tick();
    reopen = 1'b0;
    pulse(0, 1);
    seal = 1'b1;
    sb_q.push_back({4'd1, 4'd0});
    tick();
    seal = 1'b0;
    chk("t1_pre_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("t1_async_valid", 32'(out_valid), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    chk("t1_async_ops", {24'd0, op_a, op_b}, 32'd0);
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_after_valid", 32'(out_valid), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
